// File: rtl/tx_pkg.sv
// Shared definitions for the serial transmitter: FSM encoding, frame constants
// and the idle line level.
package tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int DATA_BITS  = 8;
  localparam int START_BITS = 1;
  localparam int STOP_BITS  = 1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Divider counter width; a single-cycle bit still needs one counter bit.
  function automatic int div_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Word FIFO ahead of the serializer. Count is kept separately from the pointers
// so full/empty never alias; FULL is a registered copy of count==DEPTH.
module tx_fifo
  import tx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     wr_en,
  input  logic [7:0]               din,
  input  logic                     rd_en,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          full_reg;
  logic [7:0]    dout_reg;
  logic          do_wr;
  logic          do_rd;

  assign do_wr = wr_en && !full_reg;
  assign do_rd = rd_en && (count_reg != '0);

  always_comb begin
    count_next = count_reg;
    if (do_wr && !do_rd)
      count_next = count_reg + CW'(1);
    else if (!do_wr && do_rd)
      count_next = count_reg - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
    end else begin
      if (do_wr)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_rd)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
      full_reg  <= (count_next == DEPTH_C);
    end
  end

  // Registered head read: dout holds the word at the head one cycle later.
  always_ff @(posedge clk) begin
    if (do_wr)
      mem[wr_ptr_reg] <= din;
    dout_reg <= mem[rd_ptr_reg];
  end

  assign dout  = dout_reg;
  assign count = count_reg;
  assign full  = full_reg;
  assign empty = (count_reg == '0);

endmodule

// File: rtl/tx_serializer.sv
// Buffers controller words and sends each as start / 8 data LSB-first /
// optional even parity / stop. Overflow is flagged sticky, never back-pressured.
module tx_serializer
  import tx_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int DIV       = 4,
  parameter int PARITY_EN = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENA,
  input  logic [7:0] DIN,
  input  logic       DVALID,
  input  logic       DERR,
  output logic       TXD,
  output logic       BUSY,
  output logic       FULL,
  output logic       OVF
);

  localparam int DW = div_width(DIV);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

  tx_state_t     state_reg;
  tx_state_t     state_next;
  logic [DW-1:0] div_cnt_reg;
  logic [2:0]    bit_cnt_reg;
  logic [7:0]    shift_reg;
  logic          parity_reg;
  logic          ovf_reg;

  logic          bit_end;
  logic          have_word;
  logic          frame_ready;
  logic          pop;
  logic          wr_en;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;

  assign wr_en       = DVALID && !DERR;
  assign bit_end     = (div_cnt_reg == DIV_LAST);
  assign have_word   = (fifo_count != '0) && !fifo_empty;
  assign frame_ready = ENA && have_word;
  assign pop         = frame_ready &&
                       ((state_reg == IDLE) || ((state_reg == STOP) && bit_end));

  tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (CLK),
    .srst  (RESET),
    .wr_en (wr_en),
    .din   (DIN),
    .rd_en (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge CLK) begin
    if (RESET)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (frame_ready) state_next = START;
      START:  if (bit_end) state_next = DATA;
      DATA:   if (bit_end && (bit_cnt_reg == BIT_LAST))
                state_next = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY: if (bit_end) state_next = STOP;
      STOP:   if (bit_end) state_next = frame_ready ? START : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    TXD = IDLE_LEVEL;
    case (state_reg)
      START:   TXD = ~IDLE_LEVEL;
      DATA:    TXD = shift_reg[0];
      PARITY:  TXD = parity_reg;
      default: TXD = IDLE_LEVEL;
    endcase
  end

  assign BUSY = (state_reg != IDLE);
  assign FULL = fifo_full;
  assign OVF  = ovf_reg;

  // The FIFO read is registered, so the popped word is captured during the
  // first start-bit cycle; it is not needed on the line until DATA.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      div_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
      ovf_reg     <= 1'b0;
    end else begin
      if ((state_reg == IDLE) || bit_end)
        div_cnt_reg <= '0;
      else
        div_cnt_reg <= div_cnt_reg + DW'(1);

      if (state_reg != DATA)
        bit_cnt_reg <= '0;
      else if (bit_end)
        bit_cnt_reg <= bit_cnt_reg + 3'd1;

      if ((state_reg == START) && (div_cnt_reg == '0)) begin
        shift_reg  <= fifo_dout;
        parity_reg <= ^fifo_dout;
      end else if ((state_reg == DATA) && bit_end) begin
        shift_reg <= {1'b0, shift_reg[7:1]};
      end

      if (DVALID && !DERR && fifo_full)
        ovf_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tx_serializer.sv
// Self-checking bench: expected frames are queued when words are written and
// compared as the line monitor decodes each frame from TXD.
module tb_tx_serializer;

  localparam int DEPTH = 4;
  localparam int DIV   = 4;
  localparam int PEN   = 1;
  localparam int NBITS = 10 + PEN;
  localparam int FRAME = NBITS * DIV;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       ENA = 1'b1;
  logic [7:0] DIN = 8'h00;
  logic       DVALID = 1'b0;
  logic       DERR = 1'b0;
  logic       TXD;
  logic       BUSY;
  logic       FULL;
  logic       OVF;

  int n_cmp = 0;
  int n_err = 0;
  int frames_seen = 0;
  int busy_len = 0;
  int last_busy_len = 0;
  logic [8:0] sb [$];

  tx_serializer #(.DEPTH(DEPTH), .DIV(DIV), .PARITY_EN(PEN)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .ENA    (ENA),
    .DIN    (DIN),
    .DVALID (DVALID),
    .DERR   (DERR),
    .TXD    (TXD),
    .BUSY   (BUSY),
    .FULL   (FULL),
    .OVF    (OVF)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One word per call; sampled at the next rising edge, returns 1ns after it.
  task automatic drive(input logic [7:0] d, input logic e);
    DIN = d; DERR = e; DVALID = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic release_bus();
    DVALID = 1'b0; DERR = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (BUSY !== 1'b0 && n < limit) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("idle_timeout", 32'(n < limit), 1);
    @(negedge CLK);
    @(posedge CLK); #1;
  endtask

  always @(negedge CLK) begin
    if (BUSY === 1'b1) begin
      busy_len <= busy_len + 1;
    end else begin
      if (busy_len != 0) last_busy_len <= busy_len;
      busy_len <= 0;
    end
  end

  // Line monitor: captures a whole frame once a start bit appears.
  initial begin : monitor
    logic       smp [FRAME];
    logic       aborted;
    logic       unstable;
    logic [7:0] data;
    logic [8:0] exp;
    forever begin
      @(negedge CLK);
      if (TXD === 1'b0 && RESET === 1'b0) begin
        aborted = 1'b0;
        smp[0] = TXD;
        for (int i = 1; i < FRAME; i++) begin
          @(negedge CLK);
          if (RESET) aborted = 1'b1;
          smp[i] = TXD;
        end
        if (!aborted) begin
          unstable = 1'b0;
          for (int k = 0; k < NBITS; k++)
            for (int j = 1; j < DIV; j++)
              if (smp[k*DIV+j] !== smp[k*DIV]) unstable = 1'b1;
          for (int b = 0; b < 8; b++) data[b] = smp[(b+1)*DIV];
          frames_seen++;
          $display("frame %0d: data=%02h parity=%b stop=%b", frames_seen, data,
                   smp[9*DIV], smp[10*DIV]);
          chk("bit_stable", 32'(unstable), 0);
          chk("stop_bit", 32'(smp[10*DIV]), 1);
          chk("frame_expected", 32'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            exp = sb.pop_front();
            chk("frame_par_data", {23'd0, smp[9*DIV], data}, {23'd0, exp});
          end
        end
      end
    end
  end

  initial begin : watchdog
    #(200000 * 10);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int bad;
    // Reset state
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    chk("rst_txd", 32'(TXD), 1);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_full", 32'(FULL), 0);
    chk("rst_ovf", 32'(OVF), 0);

    // Single word A5: latency, bit pattern, 44-cycle BUSY
    sb.push_back({1'b0, 8'hA5});
    drive(8'hA5, 1'b0);
    release_bus();
    chk("lat_early_txd", 32'(TXD), 1);
    @(posedge CLK); #1;
    chk("lat_start_txd", 32'(TXD), 0);
    chk("lat_start_busy", 32'(BUSY), 1);
    wait_idle(200);
    chk("busy_single", last_busy_len, 44);

    // Three back-to-back words, parity 1,1,0, no gap
    sb.push_back({1'b1, 8'h01});
    sb.push_back({1'b1, 8'h80});
    sb.push_back({1'b0, 8'hFF});
    drive(8'h01, 1'b0);
    drive(8'h80, 1'b0);
    drive(8'hFF, 1'b0);
    release_bus();
    wait_idle(400);
    chk("busy_burst", last_busy_len, 132);
    chk("sb_empty_burst", sb.size(), 0);

    // ENA low: fill FIFO, overflow on fifth word
    ENA = 1'b0;
    sb.push_back({1'b1, 8'h10});
    sb.push_back({1'b0, 8'h11});
    sb.push_back({1'b0, 8'h12});
    sb.push_back({1'b1, 8'h13});
    drive(8'h10, 1'b0); chk("full_w1", 32'(FULL), 0);
    drive(8'h11, 1'b0); chk("full_w2", 32'(FULL), 0);
    drive(8'h12, 1'b0); chk("full_w3", 32'(FULL), 0);
    drive(8'h13, 1'b0); chk("full_w4", 32'(FULL), 1);
    chk("ovf_w4", 32'(OVF), 0);
    drive(8'h14, 1'b0); chk("ovf_w5", 32'(OVF), 1);
    release_bus();
    chk("ena0_txd", 32'(TXD), 1);
    chk("ena0_busy", 32'(BUSY), 0);
    ENA = 1'b1;
    @(posedge CLK); #1;
    chk("full_after_pop", 32'(FULL), 0);
    chk("ovf_after_pop", 32'(OVF), 1);
    wait_idle(400);
    chk("busy_four", last_busy_len, 4 * FRAME);
    chk("ovf_sticky", 32'(OVF), 1);
    chk("sb_empty_four", sb.size(), 0);

    // DERR word is discarded silently
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    chk("rst2_ovf", 32'(OVF), 0);
    drive(8'h3C, 1'b1);
    release_bus();
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      if (BUSY !== 1'b0 || TXD !== 1'b1) bad++;
      @(posedge CLK); #1;
    end
    chk("derr_quiet", bad, 0);
    chk("derr_full", 32'(FULL), 0);
    chk("derr_ovf", 32'(OVF), 0);

    // RESET during data bit 3 with a second word queued
    sb.push_back({1'b0, 8'h5A});
    sb.push_back({1'b0, 8'hC3});
    drive(8'h5A, 1'b0);
    drive(8'hC3, 1'b0);
    release_bus();
    repeat (17) @(posedge CLK);
    #1 RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    sb.delete();
    chk("abort_txd", 32'(TXD), 1);
    chk("abort_busy", 32'(BUSY), 0);
    chk("abort_full", 32'(FULL), 0);
    chk("abort_ovf", 32'(OVF), 0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (BUSY !== 1'b0 || TXD !== 1'b1) bad++;
      @(posedge CLK); #1;
    end
    chk("abort_no_frames", bad, 0);

    // ENA dropped during parity with a word queued
    sb.push_back({1'b0, 8'h96});
    sb.push_back({1'b1, 8'h01});
    drive(8'h96, 1'b0);
    drive(8'h01, 1'b0);
    release_bus();
    repeat (36) @(posedge CLK);
    #1 ENA = 1'b0;
    repeat (8) @(posedge CLK);
    #1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (BUSY !== 1'b0 || TXD !== 1'b1) bad++;
      @(posedge CLK); #1;
    end
    chk("ena_hold_idle", bad, 0);
    chk("ena_hold_len", last_busy_len, FRAME);
    ENA = 1'b1;
    @(posedge CLK); #1;
    chk("ena_resume_txd", 32'(TXD), 0);
    chk("ena_resume_busy", 32'(BUSY), 1);
    wait_idle(200);
    chk("sb_empty_end", sb.size(), 0);
    chk("frames_total", frames_seen, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
